// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar sweep control unit: state encodings,
// the control-word layout and its per-state decode.
package sonar_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        MEDE           = 4'h2,
        AGUARDA_MEDIDA = 4'h3,
        FALHA          = 4'h4,
        TRANSMITE      = 4'h5,
        AGUARDA_TX     = 4'h6,
        PROXIMO_CHAR   = 4'h7,
        ESPERA_2S      = 4'h8,
        GIRA           = 4'h9,
        ERRO           = 4'hA
    } estado_t;

    // Characters per "ang,dist#" frame.
    localparam int TAM_QUADRO = 8;

    typedef struct packed {
        logic medir;
        logic zera_timeout_echo;
        logic conta_timeout_echo;
        logic partida_serial;
        logic conta_ascii;
        logic zera_contador_ascii;
        logic conta_angulo;
        logic reset_circuito;
        logic erro;
    } controle_t;

    function automatic controle_t decodifica(input estado_t e, input logic fim_serial);
        controle_t c;
        c = '0;
        case (e)
            PREPARA: begin
                c.reset_circuito      = 1'b1;
                c.zera_contador_ascii = 1'b1;
                c.zera_timeout_echo   = 1'b1;
            end
            MEDE: begin
                c.medir             = 1'b1;
                c.zera_timeout_echo = 1'b1;
            end
            AGUARDA_MEDIDA: c.conta_timeout_echo = 1'b1;
            TRANSMITE:      c.partida_serial     = 1'b1;
            PROXIMO_CHAR: begin
                if (fim_serial) c.zera_contador_ascii = 1'b1;
                else            c.conta_ascii         = 1'b1;
            end
            GIRA:    c.conta_angulo = 1'b1;
            ERRO:    c.erro         = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sonar_varredura_uc.sv
// Moore control unit for the sonar sweep: measure (with bounded retries),
// send one 8-character frame, wait for the 2 s tick, then step the servo.
module sonar_varredura_uc
    import sonar_pkg::*;
#(
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pronto_medida,
    input  logic       timeout_echo,
    input  logic       pronto_transmissao,
    input  logic       fim_serial,
    input  logic       dois_segundos,
    output logic       medir,
    output logic       zera_timeout_echo,
    output logic       conta_timeout_echo,
    output logic       partida_serial,
    output logic       conta_ascii,
    output logic       zera_contador_ascii,
    output logic       conta_angulo,
    output logic       reset_circuito,
    output logic       erro,
    output logic [3:0] db_estado
);

    localparam logic [2:0] ULTIMA_TENTATIVA = 3'(MAX_TENTATIVAS - 1);

    estado_t    estado, proximo;
    logic [2:0] tentativas;
    controle_t  ctrl;

    always_comb begin
        // NOTE: assigning a default before the case keeps this block purely
        // combinational; a path that left proximo unassigned would infer a latch.
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = ligar ? PREPARA : INICIAL;
            PREPARA:        proximo = MEDE;
            MEDE:           proximo = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
                if (pronto_medida)     proximo = TRANSMITE;
                else if (timeout_echo) proximo = FALHA;
                else                   proximo = AGUARDA_MEDIDA;
            end
            FALHA:          proximo = (tentativas == ULTIMA_TENTATIVA) ? ERRO : MEDE;
            TRANSMITE:      proximo = AGUARDA_TX;
            AGUARDA_TX:     proximo = pronto_transmissao ? PROXIMO_CHAR : AGUARDA_TX;
            PROXIMO_CHAR:   proximo = fim_serial ? ESPERA_2S : TRANSMITE;
            ESPERA_2S: begin
                if (!ligar)             proximo = INICIAL;
                else if (dois_segundos) proximo = GIRA;
                else                    proximo = ESPERA_2S;
            end
            GIRA:           proximo = MEDE;
            ERRO:           proximo = ligar ? ERRO : INICIAL;
            default:        proximo = INICIAL;
        endcase
    end

    // Outputs are registered from the decode of the state being entered, so
    // they always equal the decode of the current state register. The
    // PROXIMO_CHAR branch samples fim_serial on entry; the ASCII selector only
    // moves on conta_ascii, so it holds the same value at the exit edge.
    always_ff @(posedge clock) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            estado     <= INICIAL;
            tentativas <= '0;
            ctrl       <= '0;
        end else begin
            estado <= proximo;
            ctrl   <= decodifica(proximo, fim_serial);
            if (estado == PREPARA || (estado == AGUARDA_MEDIDA && pronto_medida))
                tentativas <= '0;
            else if (estado == FALHA && tentativas != 3'd7)
                tentativas <= tentativas + 3'd1;
        end
    end

    assign medir               = ctrl.medir;
    assign zera_timeout_echo   = ctrl.zera_timeout_echo;
    assign conta_timeout_echo  = ctrl.conta_timeout_echo;
    assign partida_serial      = ctrl.partida_serial;
    assign conta_ascii         = ctrl.conta_ascii;
    assign zera_contador_ascii = ctrl.zera_contador_ascii;
    assign conta_angulo        = ctrl.conta_angulo;
    assign reset_circuito      = ctrl.reset_circuito;
    assign erro                = ctrl.erro;
    assign db_estado           = estado;

endmodule

// File: tb/tb_sonar_varredura_uc.sv
// Scoreboard bench for sonar_varredura_uc: a datapath stub answers the
// controller, a sweep model queues the expected state trajectory.
module tb_sonar_varredura_uc;
    import sonar_pkg::*;

    localparam int MAX_T = 3;

    logic       clock = 1'b0;
    logic       reset, ligar;
    logic       pronto_medida, timeout_echo, pronto_transmissao, fim_serial, dois_segundos;
    logic       medir, zera_timeout_echo, conta_timeout_echo, partida_serial, conta_ascii;
    logic       zera_contador_ascii, conta_angulo, reset_circuito, erro;
    logic [3:0] db_estado;

    sonar_varredura_uc #(.MAX_TENTATIVAS(MAX_T)) dut (
        .clock(clock), .reset(reset), .ligar(ligar),
        .pronto_medida(pronto_medida), .timeout_echo(timeout_echo),
        .pronto_transmissao(pronto_transmissao), .fim_serial(fim_serial),
        .dois_segundos(dois_segundos),
        .medir(medir), .zera_timeout_echo(zera_timeout_echo),
        .conta_timeout_echo(conta_timeout_echo), .partida_serial(partida_serial),
        .conta_ascii(conta_ascii), .zera_contador_ascii(zera_contador_ascii),
        .conta_angulo(conta_angulo), .reset_circuito(reset_circuito),
        .erro(erro), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_pass = 0;

    task automatic check(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        n_checks++;
        if (obtido === esperado) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nome, obtido, esperado);
    endtask

    typedef enum int {OK_MEDIDA, TIMEOUT, SIMULTANEO} resultado_t;

    logic [3:0] exp_estados[$];
    resultado_t resultados[$];

    int n_medir = 0, n_partida = 0, n_ascii = 0, n_angulo = 0, n_prepara = 0;
    int e_medir = 0, e_partida = 0, e_ascii = 0, e_angulo = 0;

    // One angle of the sweep: `timeouts` failed echoes, then (if the retry
    // budget allows) a good measurement of type `tipo` and a full frame.
    task automatic modela_angulo(input int timeouts, input resultado_t tipo, input bit gira);
        for (int t = 0; t < timeouts; t++) begin
            resultados.push_back(TIMEOUT);
            exp_estados.push_back(4'h2);
            exp_estados.push_back(4'h3);
            exp_estados.push_back(4'h4);
            e_medir++;
            if (t + 1 == MAX_T) begin
                exp_estados.push_back(4'hA);
                return;
            end
        end
        resultados.push_back(tipo);
        e_medir++;
        exp_estados.push_back(4'h2);
        exp_estados.push_back(4'h3);
        for (int c = 0; c < TAM_QUADRO; c++) begin
            exp_estados.push_back(4'h5);
            exp_estados.push_back(4'h6);
            exp_estados.push_back(4'h7);
        end
        e_partida += TAM_QUADRO;
        e_ascii   += TAM_QUADRO - 1;
        exp_estados.push_back(4'h8);
        if (gira) begin
            exp_estados.push_back(4'h9);
            e_angulo++;
        end else begin
            exp_estados.push_back(4'h0);
        end
    endtask

    // Datapath stub: answers measurements/characters after a delay, keeps the
    // ASCII selector and a free-running 2 s tick.
    int pm_cnt = 0, to_cnt = 0, ambos_cnt = 0, pt_cnt = 0, idx = 0, cyc = 0;
    initial begin
        pronto_medida = 0; timeout_echo = 0; pronto_transmissao = 0;
        fim_serial = 0; dois_segundos = 0;
        forever begin
            @(negedge clock);
            pronto_medida = 0; timeout_echo = 0; pronto_transmissao = 0;
            fim_serial = (idx == TAM_QUADRO - 1);
            cyc++;
            dois_segundos = (cyc % 200 == 0);
            if (pm_cnt > 0)    begin pm_cnt--;    if (pm_cnt == 0)    pronto_medida = 1; end
            if (to_cnt > 0)    begin to_cnt--;    if (to_cnt == 0)    timeout_echo = 1; end
            if (ambos_cnt > 0) begin ambos_cnt--; if (ambos_cnt == 0) begin pronto_medida = 1; timeout_echo = 1; end end
            if (pt_cnt > 0)    begin pt_cnt--;    if (pt_cnt == 0)    pronto_transmissao = 1; end
            if (reset) begin
                pm_cnt = 0; to_cnt = 0; ambos_cnt = 0; pt_cnt = 0; idx = 0;
            end else begin
                if (medir) begin
                    resultado_t r;
                    int atraso;
                    n_medir++;
                    r = (resultados.size() != 0) ? resultados.pop_front() : OK_MEDIDA;
                    atraso = (n_angulo < 4) ? 5 : int'($urandom_range(2, 8));
                    case (r)
                        TIMEOUT:    to_cnt    = atraso;
                        SIMULTANEO: ambos_cnt = atraso;
                        default:    pm_cnt    = atraso;
                    endcase
                end
                if (partida_serial) begin
                    n_partida++;
                    pt_cnt = (n_angulo < 4) ? 3 : int'($urandom_range(1, 5));
                end
                if (conta_ascii)         begin idx++; n_ascii++; end
                if (zera_contador_ascii) idx = 0;
                if (conta_angulo)        n_angulo++;
                if (reset_circuito)      n_prepara++;
            end
        end
    end

    // Monitor: every change of db_estado must match the head of the queue.
    logic [3:0] estado_ant = 4'h0;
    initial begin
        forever begin
            @(negedge clock);
            if (db_estado !== estado_ant) begin
                if (exp_estados.size() == 0) begin
                    n_checks++;
                    $display("FAIL estado_inesperado: got 0x%0h, required no transition", db_estado);
                end else begin
                    check("sequencia_estado", 32'(db_estado), 32'(exp_estados.pop_front()));
                end
                estado_ant = db_estado;
            end
        end
    end

    task automatic espera_fila(input string nome, input int limite);
        int c = 0;
        while (exp_estados.size() != 0 && c < limite) begin
            @(negedge clock); #2;
            c++;
        end
        check(nome, exp_estados.size(), 0);
    endtask

    task automatic espera_estado(input string nome, input logic [3:0] alvo, input int limite);
        int c = 0;
        while (db_estado !== alvo && c < limite) begin
            @(negedge clock); #2;
            c++;
        end
        check(nome, 32'(db_estado), 32'(alvo));
    endtask

    function automatic logic [8:0] saidas();
        return {medir, zera_timeout_echo, conta_timeout_echo, partida_serial, conta_ascii,
                zera_contador_ascii, conta_angulo, reset_circuito, erro};
    endfunction

    initial begin
        int p0, a0;
        reset = 1; ligar = 0;
        repeat (3) @(negedge clock);
        #2;
        check("reset_estado", 32'(db_estado), 32'h0);
        check("reset_saidas", 32'(saidas()), 32'h0);
        reset = 0;
        repeat (3) @(negedge clock);
        #2;
        check("ocioso_sem_ligar", 32'(db_estado), 32'h0);

        // Nominal, random retries, simultaneous done/timeout, two retries,
        // then a fresh angle that exhausts the retry budget.
        exp_estados.push_back(4'h1);
        for (int a = 0; a < 4; a++) modela_angulo(0, OK_MEDIDA, 1);
        for (int a = 0; a < 4; a++) modela_angulo(int'($urandom_range(0, MAX_T - 1)), OK_MEDIDA, 1);
        modela_angulo(0, SIMULTANEO, 1);
        modela_angulo(2, OK_MEDIDA, 1);
        modela_angulo(MAX_T, OK_MEDIDA, 1);
        @(negedge clock);
        ligar = 1;
        espera_fila("fila_varredura", 30000);
        check("total_medir",   n_medir,   e_medir);
        check("total_partida", n_partida, e_partida);
        check("total_ascii",   n_ascii,   e_ascii);
        check("total_angulo",  n_angulo,  e_angulo);
        check("total_prepara", n_prepara, 1);
        p0 = n_partida;
        repeat (20) @(negedge clock);
        #2;
        check("erro_mantido_estado", 32'(db_estado), 32'hA);
        check("erro_saida", 32'(saidas()), 32'h1);
        check("erro_sem_partida", n_partida, p0);

        ligar = 0;
        exp_estados.push_back(4'h0);
        @(negedge clock); #2;
        check("erro_sai_estado", 32'(db_estado), 32'h0);
        check("erro_sai_flag", 32'(erro), 32'h0);

        // Stop request mid-frame: frame completes, no servo step.
        a0 = n_angulo; p0 = n_partida;
        exp_estados.push_back(4'h1);
        modela_angulo(0, OK_MEDIDA, 0);
        ligar = 1;
        espera_estado("parada_aguarda_tx", 4'h6, 500);
        ligar = 0;
        espera_fila("fila_parada", 2000);
        check("parada_partidas", n_partida - p0, TAM_QUADRO);
        check("parada_sem_giro", n_angulo, a0);

        // Synchronous reset in AGUARDA_TX, raised between edges.
        exp_estados.push_back(4'h1);
        exp_estados.push_back(4'h2);
        exp_estados.push_back(4'h3);
        exp_estados.push_back(4'h5);
        exp_estados.push_back(4'h6);
        exp_estados.push_back(4'h0);
        resultados.push_back(OK_MEDIDA);
        ligar = 1;
        espera_estado("reset_aguarda_tx", 4'h6, 500);
        reset = 1;
        #1;
        check("reset_antes_borda", 32'(db_estado), 32'h6);
        @(negedge clock); #2;
        check("reset_meio_estado", 32'(db_estado), 32'h0);
        check("reset_meio_saidas", 32'(saidas()), 32'h0);
        reset = 0; ligar = 0;
        espera_fila("fila_reset", 100);
        repeat (5) @(negedge clock);
        #2;
        check("pos_reset_ocioso", 32'(db_estado), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, required finish before 100000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
